// File: rtl/cam_frame_writer.sv
// cam_frame_writer
// Capture-side writer for the original-image frame buffer. Consumes the
// synchronised OV7670 RGB444 byte stream (QQVGA 160x120), keeps the even
// columns of even rows (80x60), packs each kept pixel to 12 bits and writes
// it to the buffer at a linear, incrementing address.
//
// Ports
//   clk          : clock, all logic on the rising edge
//   rst          : asynchronous reset, active-low
//   cam_vsync    : synchronised vsync, high = vertical blanking
//   cam_href     : synchronised href, high = active line bytes
//   cam_data_en  : one-cycle strobe per camera byte
//   cam_data     : camera byte, valid with cam_data_en
//   cap_we       : buffer write enable, one pulse per stored pixel
//   cap_addr     : buffer write address, held between writes
//   cap_pxl      : pixel {R,G,B} nibbles, held between writes
//   frame_done   : one-cycle pulse, one clk after the write to the last address
//   frame_err    : one-cycle pulse, frame cut short by vsync
module cam_frame_writer #(
  parameter int unsigned c_in_cols     = 160,
  parameter int unsigned c_in_rows     = 120,
  parameter int unsigned c_img_cols    = 80,
  parameter int unsigned c_img_rows    = 60,
  parameter int unsigned c_img_pxls    = c_img_cols * c_img_rows,
  parameter int unsigned c_nb_img_pxls = 13,
  parameter int unsigned c_nb_buf      = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cam_vsync,
  input  logic                     cam_href,
  input  logic                     cam_data_en,
  input  logic [7:0]               cam_data,
  output logic                     cap_we,
  output logic [c_nb_img_pxls-1:0] cap_addr,
  output logic [c_nb_buf-1:0]      cap_pxl,
  output logic                     frame_done,
  output logic                     frame_err
);

  localparam int unsigned col_w = 8;
  localparam int unsigned row_w = 7;

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_VBLANK = 2'd1,
    S_FRAME  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                   state, state_n;
  logic                     vsync_d, href_d;
  logic                     phase, phase_n;
  logic [3:0]               r_nib, r_nib_n;
  logic [col_w-1:0]         col, col_n;
  logic [row_w-1:0]         row, row_n;
  logic [c_nb_img_pxls-1:0] wr_addr, wr_addr_n;
  logic                     done_pend, done_pend_n;
  logic                     cap_we_n, frame_done_n, frame_err_n;
  logic [c_nb_img_pxls-1:0] cap_addr_n;
  logic [c_nb_buf-1:0]      cap_pxl_n;

  logic vsync_rise, vsync_fall, href_fall, byte_ok, store_ok, last_addr;

  assign vsync_rise = cam_vsync & ~vsync_d;
  assign vsync_fall = ~cam_vsync & vsync_d;
  assign href_fall  = ~cam_href & href_d;
  // vsync wins over href: a byte seen during vsync is never captured
  assign byte_ok    = cam_data_en & cam_href & ~cam_vsync;
  // decimation window: even row, even column, inside the active area
  assign store_ok   = ~row[0] & ~col[0] &
                      (col < col_w'(c_in_cols)) & (row < row_w'(c_in_rows));
  assign last_addr  = (wr_addr == c_nb_img_pxls'(c_img_pxls - 1));

  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_SYNC;
      vsync_d    <= 1'b0;
      href_d     <= 1'b0;
      phase      <= 1'b0;
      r_nib      <= '0;
      col        <= '0;
      row        <= '0;
      wr_addr    <= '0;
      done_pend  <= 1'b0;
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_pxl    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      vsync_d    <= cam_vsync;
      href_d     <= cam_href;
      phase      <= phase_n;
      r_nib      <= r_nib_n;
      col        <= col_n;
      row        <= row_n;
      wr_addr    <= wr_addr_n;
      done_pend  <= done_pend_n;
      cap_we     <= cap_we_n;
      cap_addr   <= cap_addr_n;
      cap_pxl    <= cap_pxl_n;
      frame_done <= frame_done_n;
      frame_err  <= frame_err_n;
    end
  end

  // next-state, counters and write generation
  always_comb begin
    state_n      = state;
    phase_n      = phase;
    r_nib_n      = r_nib;
    col_n        = col;
    row_n        = row;
    wr_addr_n    = wr_addr;
    done_pend_n  = 1'b0;
    cap_we_n     = 1'b0;
    cap_addr_n   = cap_addr;
    cap_pxl_n    = cap_pxl;
    frame_done_n = done_pend;
    frame_err_n  = 1'b0;

    case (state)
      S_SYNC: begin
        // only a full vblank after reset may open a frame
        if (cam_vsync) state_n = S_VBLANK;
      end

      S_VBLANK: begin
        if (vsync_fall) begin
          state_n   = S_FRAME;
          row_n     = '0;
          col_n     = '0;
          phase_n   = 1'b0;
          wr_addr_n = '0;
        end
      end

      S_FRAME: begin
        if (vsync_rise) begin
          // last address not reached, otherwise we would be in S_DONE
          state_n     = S_VBLANK;
          frame_err_n = 1'b1;
        end else if (href_fall) begin
          // end of line: any half pixel is dropped
          row_n   = (row == '1) ? row : row + row_w'(1);
          col_n   = '0;
          phase_n = 1'b0;
        end else if (byte_ok) begin
          if (!phase) begin
            r_nib_n = cam_data[3:0];
            phase_n = 1'b1;
          end else begin
            phase_n = 1'b0;
            col_n   = (col == '1) ? col : col + col_w'(1);
            if (store_ok) begin
              cap_we_n   = 1'b1;
              cap_addr_n = wr_addr;
              cap_pxl_n  = c_nb_buf'({r_nib, cam_data});
              if (last_addr) begin
                wr_addr_n   = '0;
                state_n     = S_DONE;
                done_pend_n = 1'b1;
              end else begin
                wr_addr_n = wr_addr + c_nb_img_pxls'(1);
              end
            end
          end
        end
      end

      S_DONE: begin
        if (vsync_rise) state_n = S_VBLANK;
      end

      default: state_n = S_SYNC;
    endcase
  end

endmodule

// File: tb/tb_cam_frame_writer.sv
// Bench for cam_frame_writer: camera byte stream driver, scoreboard of
// expected buffer writes and per-scenario checks.
module tb_cam_frame_writer;

  logic        clk;
  logic        rst;
  logic        cam_vsync;
  logic        cam_href;
  logic        cam_data_en;
  logic [7:0]  cam_data;
  logic        cap_we;
  logic [12:0] cap_addr;
  logic [11:0] cap_pxl;
  logic        frame_done;
  logic        frame_err;

  typedef struct {
    logic [12:0] addr;
    logic [11:0] pxl;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          we_cnt   = 0;
  int          done_cnt = 0;
  int          err_cnt  = 0;
  logic        prev_we  = 1'b0;
  logic [12:0] prev_addr = '0;

  cam_frame_writer dut (
    .clk        (clk),
    .rst        (rst),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data_en(cam_data_en),
    .cam_data   (cam_data),
    .cap_we     (cap_we),
    .cap_addr   (cap_addr),
    .cap_pxl    (cap_pxl),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // scoreboard: every write must match the oldest expected pixel
  always @(negedge clk) begin
    if (rst) begin
      if (cap_we) begin
        we_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: addr=%0d pxl=%h, none expected", cap_addr, cap_pxl);
        end else begin
          e = exp_q.pop_front();
          if (cap_addr !== e.addr || cap_pxl !== e.pxl) begin
            n_fail++;
            $display("FAIL write_data: got addr=%0d pxl=%h, want addr=%0d pxl=%h",
                     cap_addr, cap_pxl, e.addr, e.pxl);
          end
        end
      end
      if (frame_done) begin
        done_cnt++;
        n_checks++;
        if (!(prev_we === 1'b1 && prev_addr === 13'd4799)) begin
          n_fail++;
          $display("FAIL done_timing: prev_we=%b prev_addr=%0d, want prev_we=1 prev_addr=4799",
                   prev_we, prev_addr);
        end
      end
      if (frame_err) err_cnt++;
      prev_we   = cap_we;
      prev_addr = cap_addr;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic frame_start();
    cam_vsync = 1'b1; cam_href = 1'b0; cam_data_en = 1'b0;
    repeat (4) @(negedge clk);
    cam_vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    cam_vsync = 1'b1; cam_href = 1'b0; cam_data_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam_href = 1'b1; cam_data_en = 1'b1; cam_data = b;
    @(negedge clk);
  endtask

  task automatic line_end();
    cam_href = 1'b0; cam_data_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // drives one pixel; pushes its expected write when it lands in the kept grid
  task automatic send_pixel(input int row, input int col, input logic [7:0] b0,
                            input logic [7:0] b1, input bit can_store);
    exp_t x;
    if (can_store && (row % 2 == 0) && (col % 2 == 0) && col < 160 && row < 120) begin
      x.addr = 13'((row / 2) * 80 + col / 2);
      x.pxl  = {b0[3:0], b1};
      exp_q.push_back(x);
    end
    send_byte(b0);
    send_byte(b1);
  endtask

  task automatic test_reset();
    int we0, err0, done0;
    rst = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data_en = 1'b0; cam_data = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (cap_we !== 1'b0 || frame_done !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: we=%b done=%b err=%b, want 0", cap_we, frame_done, frame_err);
    end
    n_checks++;
    if (cap_addr !== 13'd0 || cap_pxl !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%0d pxl=%h, want 0", cap_addr, cap_pxl);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    we0 = we_cnt; err0 = err_cnt; done0 = done_cnt;
    frame_start();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 160; c++) send_pixel(r, c, 8'h07, 8'h21, 1'b1);
      line_end();
    end
    for (int c = 0; c < 25; c++) send_pixel(3, c, 8'h07, 8'h21, 1'b0);
    rst = 1'b0;
    for (int c = 25; c < 30; c++) send_pixel(3, c, 8'h07, 8'h21, 1'b0);
    n_checks++;
    if (cap_addr !== 13'd0 || cap_pxl !== 12'd0 || cap_we !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_reset_outputs: we=%b addr=%0d pxl=%h, want 0",
               cap_we, cap_addr, cap_pxl);
    end
    rst = 1'b1;
    for (int c = 30; c < 160; c++) send_pixel(3, c, 8'h07, 8'h21, 1'b0);
    line_end();
    for (int r = 4; r < 10; r++) begin
      for (int c = 0; c < 160; c++) send_pixel(r, c, 8'h07, 8'h21, 1'b0);
      line_end();
    end
    frame_end();
    n_checks++;
    if (we_cnt - we0 !== 160) begin
      n_fail++;
      $display("FAIL reset_write_count: got %0d, want 160", we_cnt - we0);
    end
    n_checks++;
    if (err_cnt !== err0 || done_cnt !== done0) begin
      n_fail++;
      $display("FAIL reset_no_pulses: err=%0d done=%0d, want 0 0", err_cnt - err0, done_cnt - done0);
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL reset_pending: %0d writes missing, want 0", exp_q.size());
    end
  endtask

  task automatic test_abort();
    int we0, err0, done0;
    we0 = we_cnt; err0 = err_cnt; done0 = done_cnt;
    frame_start();
    for (int r = 0; r < 30; r++) begin
      for (int c = 0; c < 160; c++) send_pixel(r, c, 8'h0A, 8'h5C, 1'b1);
      line_end();
    end
    for (int c = 0; c < 10; c++) send_pixel(30, c, 8'h0A, 8'h5C, 1'b1);
    send_byte(8'h0A);
    // vsync rises together with the byte that would complete a kept pixel
    cam_vsync = 1'b1; cam_data = 8'h5C;
    @(negedge clk);
    cam_href = 1'b0; cam_data_en = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (err_cnt - err0 !== 1) begin
      n_fail++;
      $display("FAIL abort_err_pulse: got %0d cycles, want 1", err_cnt - err0);
    end
    n_checks++;
    if (done_cnt !== done0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d, want 0", done_cnt - done0);
    end
    n_checks++;
    if (we_cnt - we0 !== 1205) begin
      n_fail++;
      $display("FAIL abort_write_count: got %0d, want 1205", we_cnt - we0);
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL abort_pending: %0d writes missing, want 0", exp_q.size());
    end
  endtask

  // 170x125 frame, constant A5C except line 2 which carries the column index,
  // odd lines end with a stray byte that must not leak into the next line
  task automatic test_full_frame();
    int we0, err0, done0;
    logic [7:0] b1;
    we0 = we_cnt; err0 = err_cnt; done0 = done_cnt;
    frame_start();
    for (int r = 0; r < 125; r++) begin
      for (int c = 0; c < 170; c++) begin
        b1 = (r == 2) ? 8'(c) : 8'h5C;
        send_pixel(r, c, 8'h0A, b1, 1'b1);
      end
      if (r % 2 == 1) send_byte(8'h03);
      line_end();
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (we_cnt - we0 !== 4800) begin
      n_fail++;
      $display("FAIL full_write_count: got %0d, want 4800", we_cnt - we0);
    end
    n_checks++;
    if (done_cnt - done0 !== 1) begin
      n_fail++;
      $display("FAIL full_done_count: got %0d, want 1", done_cnt - done0);
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL full_pending: %0d writes missing, want 0", exp_q.size());
    end
    n_checks++;
    if (cap_addr !== 13'd4799 || cap_pxl !== 12'hA5C) begin
      n_fail++;
      $display("FAIL full_hold: addr=%0d pxl=%h, want 4799 a5c", cap_addr, cap_pxl);
    end
    frame_end();
    n_checks++;
    if (err_cnt !== err0) begin
      n_fail++;
      $display("FAIL full_no_err: got %0d, want 0", err_cnt - err0);
    end
  endtask

  initial begin
    test_reset();
    test_abort();
    test_full_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
